// File: rtl/sad_block_loader_if.sv
// sad_block_loader_if
// Groups the stream, SAD-engine and control signals of the block loader.
//   in_valid / in_data / in_ready : byte stream handshake into the loader
//   go / busy                      : start request and bank ownership status
//   AB_addr / AB_rd                : read request from the SAD engine
//   A_data / B_data                : bank A / bank B read data
//   bank_release                   : one-cycle pulse, SAD result captured,
//                                    banks may be overwritten
// master: stream source + SAD engine side.  slave: the loader.
interface sad_block_loader_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              go;
  logic [ADDR_W-1:0] AB_addr;
  logic              AB_rd;
  logic [DATA_W-1:0] A_data;
  logic [DATA_W-1:0] B_data;
  logic              bank_release;
  logic              busy;

  modport master (
    output in_valid, in_data, AB_addr, AB_rd, bank_release,
    input  in_ready, go, A_data, B_data, busy
  );

  modport slave (
    input  in_valid, in_data, AB_addr, AB_rd, bank_release,
    output in_ready, go, A_data, B_data, busy
  );
endinterface

// File: rtl/sad_block_loader.sv
// sad_block_loader
// Fills bank A then bank B from a byte stream, starts the SAD engine with go,
// and serves parallel reads from both banks until the banks are released.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : sad_block_loader_if.slave (stream, read port, go/busy, release)
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD_A | accepting stream bytes into bank A, idx = write address
// LOAD_B | accepting stream bytes into bank B, idx = write address
// GO     | banks full, go held high until the engine's first read
// SERVE  | engine reading banks; waits for bank_release
module sad_block_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  sad_block_loader_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, GO, SERVE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic              in_ready_q;
  logic              go_q;
  logic              busy_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic [DATA_W-1:0] bank_a [DEPTH];
  logic [DATA_W-1:0] bank_b [DEPTH];

  logic             xfer;
  logic             idx_last;
  logic             rd_hit;
  logic             addr_ok;
  logic [IDX_W-1:0] rd_idx;

  // in_ready is only ever high in LOAD_A/LOAD_B, so it alone qualifies a transfer.
  assign xfer     = bus.in_valid && in_ready_q;
  assign idx_last = (idx == IDX_W'(DEPTH - 1));
  assign rd_hit   = bus.AB_rd && ((state == GO) || (state == SERVE));
  // Out-of-range addresses read as zero rather than aliasing into the bank.
  assign addr_ok  = (32'(bus.AB_addr) < DEPTH);
  assign rd_idx   = bus.AB_addr[IDX_W-1:0];

  // Bank storage has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (xfer && (state == LOAD_A)) bank_a[idx] <= bus.in_data;
    if (xfer && (state == LOAD_B)) bank_b[idx] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_A;
      idx        <= '0;
      in_ready_q <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      if (rd_hit) begin
        a_q <= addr_ok ? bank_a[rd_idx] : '0;
        b_q <= addr_ok ? bank_b[rd_idx] : '0;
      end

      case (state)
        LOAD_A: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (idx_last) begin
              idx   <= '0;
              state <= LOAD_B;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        LOAD_B: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (idx_last) begin
              idx        <= '0;
              state      <= GO;
              in_ready_q <= 1'b0;
              go_q       <= 1'b1;
              busy_q     <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end

        GO: begin
          // bank_release is deliberately not looked at until SERVE.
          if (bus.AB_rd) begin
            state <= SERVE;
            go_q  <= 1'b0;
          end
        end

        SERVE: begin
          if (bus.bank_release) begin
            state      <= LOAD_A;
            idx        <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end

        default: state <= LOAD_A;
      endcase
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.go       = go_q;
  assign bus.busy     = busy_q;
  assign bus.A_data   = a_q;
  assign bus.B_data   = b_q;
endmodule

// File: tb/tb_sad_block_loader.sv
module tb_sad_block_loader;
  logic clk = 1'b0;
  logic rst;

  sad_block_loader_if #(.ADDR_W(9), .DATA_W(8)) bus ();

  sad_block_loader #(.DEPTH(256), .ADDR_W(9), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_a [256];
  logic [7:0]  exp_b [256];
  logic [15:0] sb_q [$];
  bit          pend = 0;

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a read accepted at an edge is compared at the following negedge.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: read data %0h/%0h with no expected entry",
                   bus.A_data, bus.B_data);
        end else begin
          e = sb_q.pop_front();
          chk_eq("rd_a", bus.A_data, e[15:8]);
          chk_eq("rd_b", bus.B_data, e[7:0]);
        end
      end
      pend = bus.AB_rd && bus.busy;
    end
  end

  function automatic logic [7:0] stream_byte(input int pair, input int i);
    int j = i % 256;
    bit hi = (i >= 256);
    case (pair)
      0:       return hi ? 8'(255 - j) : 8'(j);
      1:       return hi ? 8'(j * 3) : 8'(j ^ 'h5A);
      2:       return 8'(j + 7);
      default: return hi ? 8'(j ^ 'hC3) : 8'(255 - j);
    endcase
  endfunction

  // Called at posedge+1 with in_ready already expected high.
  task automatic load_pair(input int pair, input int n, input bit rnd);
    int i = 0, cyc = 0, drops = 0, early = 0;
    bit v, rdy;
    while (i < n && cyc < 4000) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_data  = stream_byte(pair, i);
      @(negedge clk);
      rdy = bus.in_ready;
      if (!rdy) drops++;
      if (bus.go || bus.busy) early++;
      @(posedge clk);
      #1;
      if (v && rdy) begin
        if (i < 256) exp_a[i] = stream_byte(pair, i);
        else         exp_b[i - 256] = stream_byte(pair, i);
        i++;
      end
      cyc++;
    end
    chk_eq("xfer_count", i, n);
    chk_eq("ready_drops", drops, 0);
    chk_eq("early_go_busy", early, 0);
  endtask

  // Keep in_valid high with garbage: nothing may be accepted from here on.
  task automatic post_load_checks();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    @(negedge clk);
    chk_eq("go_after_load", bus.go, 1);
    chk_eq("busy_after_load", bus.busy, 1);
    chk_eq("ready_after_load", bus.in_ready, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input int addr, input int ea, input int eb);
    bus.AB_addr = addr[8:0];
    bus.AB_rd   = 1'b1;
    sb_q.push_back({ea[7:0], eb[7:0]});
    @(posedge clk);
    #1;
    bus.AB_rd = 1'b0;
  endtask

  task automatic hold_check(input int n, input int ea, input int eb);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_eq("hold_a", bus.A_data, ea);
      chk_eq("hold_b", bus.B_data, eb);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_read(input int addr, input int ea, input int eb);
    bus.in_valid     = 1'b0;
    bus.AB_addr      = addr[8:0];
    bus.AB_rd        = 1'b1;
    bus.bank_release = 1'b1;
    sb_q.push_back({ea[7:0], eb[7:0]});
    @(posedge clk);
    #1;
    bus.AB_rd        = 1'b0;
    bus.bank_release = 1'b0;
    @(negedge clk);
    chk_eq("busy_after_release", bus.busy, 0);
    chk_eq("ready_after_release", bus.in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    rst              = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.AB_addr      = '0;
    bus.AB_rd        = 1'b0;
    bus.bank_release = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", bus.in_ready, 0);
    chk_eq("rst_go", bus.go, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_a", bus.A_data, 0);
    chk_eq("rst_b", bus.B_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pair 0 with in_valid held high: A=00..FF, B=FF..00
    load_pair(0, 512, 1'b0);
    post_load_checks();

    // release during GO is ignored
    bus.bank_release = 1'b1;
    @(posedge clk);
    #1;
    bus.bank_release = 1'b0;
    @(negedge clk);
    chk_eq("go_hold_on_release", bus.go, 1);
    chk_eq("busy_hold_on_release", bus.busy, 1);
    @(posedge clk);
    #1;

    do_read('h000, 'h00, 'hFF);
    @(negedge clk);
    chk_eq("go_drop_after_rd", bus.go, 0);
    chk_eq("busy_in_serve", bus.busy, 1);
    chk_eq("ready_in_serve", bus.in_ready, 0);
    @(posedge clk);
    #1;

    do_read('h07F, 'h7F, 'h80);
    hold_check(2, 'h7F, 'h80);
    do_read('h0FF, 'hFF, 'h00);
    do_read('h100, 'h00, 'h00);
    hold_check(3, 'h00, 'h00);

    // Garbage bytes offered during GO/SERVE must not have landed in the banks
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, 255);
      do_read(a, exp_a[a], exp_b[a]);
    end
    do_read('h1FF, 'h00, 'h00);
    release_read('h010, 'h10, 'hEF);

    // Pair 1 with random in_valid overwrites the banks
    load_pair(1, 512, 1'b1);
    post_load_checks();
    do_read('h000, 'h5A, 'h00);
    do_read('h0FF, 'hA5, 'hFD);
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, 255);
      do_read(a, exp_a[a], exp_b[a]);
    end
    release_read('h010, 'h4A, 'h30);

    // Pair 2 aborted by reset after 100 bytes of bank B
    load_pair(2, 356, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_go", bus.go, 0);
    chk_eq("arst_busy", bus.busy, 0);
    chk_eq("arst_ready", bus.in_ready, 0);
    chk_eq("arst_a", bus.A_data, 0);
    chk_eq("arst_b", bus.B_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Pair 3 must restart at A[0] and take exactly 512 transfers
    load_pair(3, 512, 1'b0);
    post_load_checks();
    do_read('h000, 'hFF, 'hC3);
    do_read('h063, 'h9C, 'hA0);
    do_read('h064, 'h9B, 'hA7);
    do_read('h0FF, 'h00, 'h3C);
    do_read('h000, 'hFF, 'hC3);
    @(negedge clk);

    // Reset while in SERVE drops busy and read data without a clock edge
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_eq("arst_serve_busy", bus.busy, 0);
    chk_eq("arst_serve_a", bus.A_data, 0);
    chk_eq("arst_serve_b", bus.B_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    chk_eq("sb_leftover", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
